// File: rtl/button_step_gen.sv
// button_step_gen: debounced push-button to single-cycle step pulses with optional auto-repeat
module button_step_gen #(
    parameter int CNT_W         = 20,
    parameter int DEB_CYCLES    = 20000,
    parameter int HOLD_CYCLES   = 500000,
    parameter int REPEAT_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic step_pulse,
    output logic btn_level,
    output logic repeat_active
);
    typedef enum logic [2:0] {IDLE, PRESS_CHK, HELD, RPT, REL_CHK} state_t;

    // The first stable sample is taken in IDLE/HELD, so the check states need DEB_CYCLES-1 more.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES > 1 ? DEB_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam bit               DEB_ONE   = DEB_CYCLES == 1;

    state_t           state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic             sync1, btn_s;
    logic             nxt_pulse, nxt_level, nxt_rpt;

    // Two-flop synchroniser for the asynchronous button pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            btn_s <= sync1;
        end
    end

    // Next-state, timer and output decode; release always takes priority over a timer expiry
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 1'b1;
        nxt_pulse = 1'b0;
        nxt_level = btn_level;
        nxt_rpt   = repeat_active;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    nxt_state = DEB_ONE ? HELD : PRESS_CHK;
                    nxt_pulse = DEB_ONE;
                    nxt_level = DEB_ONE;
                end
            end
            PRESS_CHK: begin
                if (!btn_s) begin
                    nxt_state = IDLE;
                end else if (cnt == DEB_LAST) begin
                    nxt_state = HELD;
                    nxt_pulse = 1'b1;
                    nxt_level = 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    nxt_state = DEB_ONE ? IDLE : REL_CHK;
                    nxt_level = !DEB_ONE;
                end else if (!repeat_en) begin
                    nxt_cnt = '0;
                end else if (cnt == HOLD_LAST) begin
                    nxt_state = RPT;
                    nxt_pulse = 1'b1;
                    nxt_rpt   = 1'b1;
                end
            end
            RPT: begin
                if (!btn_s) begin
                    nxt_state = DEB_ONE ? IDLE : REL_CHK;
                    nxt_level = !DEB_ONE;
                    nxt_rpt   = 1'b0;
                end else if (!repeat_en) begin
                    nxt_state = HELD;
                    nxt_rpt   = 1'b0;
                end else if (cnt == RPT_LAST) begin
                    nxt_pulse = 1'b1;
                    nxt_cnt   = '0;
                end
            end
            REL_CHK: begin
                if (btn_s) begin
                    nxt_state = HELD;
                end else if (cnt == DEB_LAST) begin
                    nxt_state = IDLE;
                    nxt_level = 1'b0;
                end
            end
            default: nxt_state = IDLE;
        endcase
        if (nxt_state != state || state == IDLE) nxt_cnt = '0;
    end

    // State, shared timer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            step_pulse    <= 1'b0;
            btn_level     <= 1'b0;
            repeat_active <= 1'b0;
        end else begin
            state         <= nxt_state;
            cnt           <= nxt_cnt;
            step_pulse    <= nxt_pulse;
            btn_level     <= nxt_level;
            repeat_active <= nxt_rpt;
        end
    end
endmodule

// File: tb/tb_button_step_gen.sv
// tb_button_step_gen: vector table plus directed sequences for button_step_gen
module tb_button_step_gen;
    logic       clk = 1'b0, rst_n = 1'b1, btn_raw = 1'b0, repeat_en = 1'b0;
    logic       step_pulse, btn_level, repeat_active;
    logic [2:0] o;
    int         total = 0, bad = 0;

    typedef struct {
        logic       btn;
        logic       ren;
        logic [2:0] exp;
    } vec_t;
    vec_t tbl[$];

    assign o = {step_pulse, btn_level, repeat_active};

    always #5 clk = ~clk;

    button_step_gen #(.CNT_W(8), .DEB_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_raw(btn_raw),
        .repeat_en(repeat_en),
        .step_pulse(step_pulse),
        .btn_level(btn_level),
        .repeat_active(repeat_active)
    );

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {pulse,level,rpt}=%b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic btn, input logic ren, input logic [2:0] exp, input int n);
        for (int i = 0; i < n; i++) tbl.push_back('{btn, ren, exp});
    endtask

    task automatic wait_pulse(input string name, input int want, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step_pulse && n < limit);
        check_int(name, n, want);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] e;
        int         n;
        #1 rst_n = 1'b0;
        #2 check("reset state", o, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // glitch of 3 cycles, clean press held ~100 cycles, release
        add(0, 0, 3'b000, 3);
        add(1, 0, 3'b000, 3);
        add(0, 0, 3'b000, 5);
        add(1, 0, 3'b000, 5);
        add(1, 0, 3'b110, 1);
        add(1, 0, 3'b010, 94);
        add(0, 0, 3'b010, 5);
        add(0, 0, 3'b000, 3);
        foreach (tbl[i]) begin
            btn_raw   = tbl[i].btn;
            repeat_en = tbl[i].ren;
            @(negedge clk);
            check($sformatf("vec%0d", i), o, tbl[i].exp);
        end

        // auto-repeat: pulses at P, P+20, P+28, ... then release
        repeat_en = 1'b1;
        btn_raw   = 1'b1;
        wait_pulse("t3 press latency", 6, 20);
        for (int off = 1; off <= 61; off++) begin
            btn_raw = off < 56;
            @(negedge clk);
            e = {off >= 20 && off < 58 && (off - 20) % 8 == 0, off < 61, off >= 20 && off < 58};
            check($sformatf("t3 off%0d", off), o, e);
        end

        // release bounce in HELD restarts the hold timer
        btn_raw = 1'b1;
        wait_pulse("t4 press latency", 6, 20);
        for (int off = 1; off <= 31; off++) begin
            btn_raw = !(off == 6 || off == 7);
            @(negedge clk);
            check($sformatf("t4 off%0d", off), o, {off == 30, 1'b1, off >= 30});
        end

        // repeat_en drop in RPT
        for (int off = 32; off <= 60; off++) begin
            repeat_en = off < 34;
            @(negedge clk);
            check($sformatf("t5 off%0d", off), o, {1'b0, 1'b1, off < 34});
        end

        // re-arm into RPT, then asynchronous reset mid-repeat
        repeat_en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!repeat_active && n < 40);
        check_int("t6 hold re-arm", n, 20);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("t6 async reset", o, 3'b000);
        @(negedge clk);
        @(negedge clk);
        check("t6 reset held", o, 3'b000);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("t6 post-reset edge%0d", k), o, k == 6 ? 3'b110 : (k == 7 ? 3'b010 : 3'b000));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/button_step_gen.md
Name: button_step_gen

Overview:
Upstream stage for the 7-segment letter sequencer. Takes a raw, bouncing push-button input and produces clean single-cycle step pulses in the clk domain. The sequencer advances its letter index on these pulses instead of clocking on the raw pin. An optional auto-repeat mode emits further pulses while the button is held.

Parameters:
- CNT_W, 20: width of the shared timing counter; must hold max(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES).
- DEB_CYCLES, 20000: consecutive stable samples required to accept a press or a release; must be >= 1.
- HOLD_CYCLES, 500000: cycles from the initial step pulse to the first auto-repeat pulse; must be >= 2.
- REPEAT_CYCLES, 200000: cycles between consecutive auto-repeat pulses; must be >= 2.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- btn_raw, input, 1: raw button, active-high, asynchronous to clk.
- repeat_en, input, 1: enables auto-repeat, sampled synchronously.
- step_pulse, output, 1: one-cycle advance pulse to the letter sequencer.
- btn_level, output, 1: debounced button state.
- repeat_active, output, 1: high while in auto-repeat.

Behaviour:
- Reset (async, rst_n=0):
  - synchroniser flops, counter and all outputs go to 0 immediately.
  - FSM goes to IDLE.
  - All outputs are registered.
- Synchroniser: 2-flop chain on btn_raw. btn_s = second flop. Only btn_s is used by the FSM.
- FSM states: IDLE, PRESS_CHK, HELD, RPT, REL_CHK. The counter cnt clears on every state change.
- IDLE: btn_s=1 -> PRESS_CHK.
- PRESS_CHK:
  - btn_s=0 -> IDLE (glitch rejected, no pulse).
  - After DEB_CYCLES consecutive btn_s=1 samples -> HELD.
  - On that transition, step_pulse=1 and btn_level=1 are set in the same cycle.
- Press latency: if btn_raw is first sampled high at edge 1 and stays high, step_pulse and btn_level are high after edge DEB_CYCLES+2.
- HELD:
  - btn_s=0 -> REL_CHK.
  - repeat_en=0: cnt held at 0.
  - repeat_en=1: cnt counts. When HOLD_CYCLES cycles have elapsed since the initial pulse -> RPT, with step_pulse=1 and repeat_active=1.
- RPT:
  - step_pulse fires every REPEAT_CYCLES cycles.
  - repeat_en=0 -> HELD, repeat_active=0, no pulse; hold timer restarts.
  - btn_s=0 -> REL_CHK, repeat_active=0.
- REL_CHK:
  - btn_s=1 before DEB_CYCLES low samples -> HELD (release bounce rejected). No pulse; btn_level stays 1; hold timer restarts from 0.
  - After DEB_CYCLES consecutive btn_s=0 samples -> IDLE, btn_level=0.
  - Release latency equals press latency (DEB_CYCLES+2 edges).
- step_pulse:
  - High for exactly 1 cycle per event; never high on two consecutive cycles.
  - Exactly one pulse per accepted press when repeat_en=0.
- Simultaneous btn_s=0 and a repeat-timer expiry in HELD/RPT: the release wins, no pulse.
- Reset mid-operation (any state): outputs drop immediately.
  - After rst_n deasserts with the button still held, a new press is accepted only after the full sync plus debounce latency.

Test Plan:
(Bench parameters: DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, CNT_W=8.)
1. Glitch rejection: btn_raw high for 3 cycles, then low -> step_pulse never asserts; btn_level stays 0; FSM returns to IDLE.
2. Clean press, repeat_en=0, held 100 cycles: exactly one step_pulse, after edge 6 counting from the first high sample; btn_level rises in the same cycle. On release, btn_level falls 6 edges after the first low sample.
3. Auto-repeat, repeat_en=1, held 60 cycles after initial pulse at cycle P:
   - pulses at P, P+20, P+28, P+36, P+44, P+52;
   - repeat_active high from P+20 until release is accepted.
4. Release bounce: in HELD, btn_raw low for 2 cycles then high -> no pulse; btn_level stays 1; next repeat pulse 20 cycles after re-entry to HELD.
5. repeat_en drop in RPT: deassert between repeat pulses -> repeat_active falls next cycle; no further pulses while held.
6. Reset mid-RPT: rst_n low -> step_pulse, btn_level, repeat_active are 0 without a clock edge. Release rst_n with btn_raw still high -> next pulse exactly 6 edges later.
